// File: rtl/vga_frame_decoder.sv
// Receive-side VGA timing/glyph checker: locks to the generator's sync timing,
// recovers pixel coordinates and decodes the 8x16 glyph window. Macro VGA_DEC_ERR_CNT_EN enables the lock-loss counter.
module vga_frame_decoder #(
  parameter int TOTAL_WIDTH   = 800,
  parameter int TOTAL_HEIGHT  = 525,
  parameter int H_SYNC_COLUMN = 704,
  parameter int V_SYNC_LINE   = 523,
  parameter int WIN_X         = 50,
  parameter int WIN_Y         = 50,
  parameter int LOCK_LINES    = 4,
  parameter int ACT_X0        = 50,
  parameter int ACT_X1        = 689,
  parameter int ACT_Y0        = 33,
  parameter int ACT_Y1        = 512
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_h_sync,
  input  logic        i_v_sync,
  input  logic        i_led_in,
  output logic [11:0] o_col,
  output logic [11:0] o_row,
  output logic        o_pix_valid,
  output logic        o_locked,
  output logic [7:0]  o_letter_code,
  output logic        o_letter_valid,
  output logic [7:0]  o_sync_err_cnt
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam logic [0:9][7:0] GLYPH_A = {8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE, 8'hFE, 8'hC6, 8'hC6, 8'hC6};
  localparam logic [0:9][7:0] GLYPH_Q = {8'hFC, 8'hFE, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'hD6, 8'hFE, 8'h6C, 8'h06};
  localparam logic [0:9][7:0] GLYPH_I = {8'hFE, 8'hFE, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'hFE, 8'hFE};
  localparam logic [11:0] CNT_SAT = 12'hFFE;

  logic        r_hs, r_vs, r_px, r_hs_d, r_vs_d, r_px_s;
  logic [11:0] r_col, r_row, r_line_cnt, r_vlines;
  state_t      r_state, w_state_nxt;
  logic [7:0]  r_good, w_good_nxt;
  logic        r_first_v, w_first_nxt;
  logic [15:0][7:0] r_cap, w_cap_fin;
  logic [7:0]  r_code, w_code;
  logic        r_lv;

  logic        w_h_edge, w_v_edge, w_col_wrap, w_line_ok, w_frame_ok;
  logic [11:0] w_line_len, w_frame_lines;
  logic        w_in_win, w_last;
  logic [3:0]  w_r;
  logic [2:0]  w_c;

  function automatic logic [7:0] glyph_row(input logic [1:0] g, input logic [3:0] r);
    logic [7:0] v;
    logic [3:0] idx;
    v   = 8'h00;
    idx = r - 4'd2;
    if (r >= 4'd2 && r <= 4'd11) begin
      case (g)
        2'd0:    v = GLYPH_A[idx];
        2'd1:    v = GLYPH_Q[idx];
        default: v = GLYPH_I[idx];
      endcase
    end
    return v;
  endfunction

  // Two-stage input path: col/row are produced from the first stage, so px is delayed once more to line up.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hs <= 1'b0; r_vs <= 1'b0; r_px <= 1'b0;
      r_hs_d <= 1'b0; r_vs_d <= 1'b0; r_px_s <= 1'b0;
    end else begin
      r_hs <= i_h_sync; r_vs <= i_v_sync; r_px <= i_led_in;
      r_hs_d <= r_hs; r_vs_d <= r_vs; r_px_s <= r_px;
    end
  end

  assign w_h_edge      = r_hs_d & ~r_hs;
  assign w_v_edge      = r_vs_d & ~r_vs;
  assign w_col_wrap    = !w_h_edge && (r_col == 12'(TOTAL_WIDTH - 1));
  assign w_line_len    = r_line_cnt + 12'd1;
  assign w_frame_lines = r_vlines + {11'd0, w_h_edge};
  assign w_line_ok     = (w_line_len == 12'(TOTAL_WIDTH));
  assign w_frame_ok    = (w_frame_lines == 12'(TOTAL_HEIGHT));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col <= '0; r_row <= '0; r_line_cnt <= '0; r_vlines <= '0;
    end else begin
      if (w_h_edge)        r_col <= 12'(H_SYNC_COLUMN);
      else if (w_col_wrap) r_col <= '0;
      else                 r_col <= r_col + 12'd1;

      if (w_v_edge)        r_row <= 12'(V_SYNC_LINE);
      else if (w_col_wrap) r_row <= (r_row == 12'(TOTAL_HEIGHT - 1)) ? 12'd0 : r_row + 12'd1;

      if (w_h_edge)                  r_line_cnt <= '0;
      else if (r_line_cnt != CNT_SAT) r_line_cnt <= r_line_cnt + 12'd1;

      if (w_v_edge)                               r_vlines <= {11'd0, w_h_edge};
      else if (w_h_edge && r_vlines != CNT_SAT)   r_vlines <= r_vlines + 12'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_first_nxt = r_first_v;
    case (r_state)
      SEARCH: begin
        w_good_nxt = '0;
        if (w_h_edge) w_state_nxt = MEASURE;
      end
      MEASURE: begin
        if (w_h_edge && !w_line_ok) begin
          w_state_nxt = SEARCH;
          w_good_nxt  = '0;
        end else begin
          if (w_h_edge && r_good != 8'hFF) w_good_nxt = r_good + 8'd1;
          if (w_v_edge && r_good >= 8'(LOCK_LINES)) begin
            w_state_nxt = LOCKED;
            w_first_nxt = 1'b1;
          end
        end
      end
      LOCKED: begin
        // The frame length seen at the first V edge after lock spans the acquisition period, so it is not judged.
        if ((w_h_edge && !w_line_ok) || (w_v_edge && !w_frame_ok && !r_first_v)) begin
          w_state_nxt = SEARCH;
          w_good_nxt  = '0;
        end else if (w_v_edge) begin
          w_first_nxt = 1'b0;
        end
      end
      default: w_state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= SEARCH; r_good <= '0; r_first_v <= 1'b0;
    end else begin
      r_state <= w_state_nxt; r_good <= w_good_nxt; r_first_v <= w_first_nxt;
    end
  end

  assign w_in_win = (r_state == LOCKED) &&
                    (r_row >= 12'(WIN_Y)) && (r_row <= 12'(WIN_Y + 15)) &&
                    (r_col >= 12'(WIN_X)) && (r_col <= 12'(WIN_X + 7));
  assign w_last   = w_in_win && (r_row == 12'(WIN_Y + 15)) && (r_col == 12'(WIN_X + 7));
  assign w_r      = 4'(r_row - 12'(WIN_Y));
  assign w_c      = 3'(r_col - 12'(WIN_X));

  always_comb begin
    w_cap_fin        = r_cap;
    w_cap_fin[15][0] = r_px_s;
  end

  always_comb begin
    logic hit;
    w_code = 8'h3F;
    hit    = 1'b0;
    for (int g = 0; g < 3; g++) begin
      hit = 1'b1;
      for (int r = 0; r < 16; r++)
        if (w_cap_fin[r] != glyph_row(2'(g), 4'(r))) hit = 1'b0;
      if (hit) w_code = (g == 0) ? 8'h41 : (g == 1) ? 8'h51 : 8'h49;
    end
  end

  // Leaving LOCKED throws away any partial window so a stale glyph can never be reported.
  always_ff @(posedge i_clk) begin
    if (i_rst || r_state != LOCKED) r_cap <= '0;
    else if (w_in_win)              r_cap[w_r][3'd7 - w_c] <= r_px_s;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_code <= 8'h00; r_lv <= 1'b0;
    end else begin
      r_lv <= w_last;
      if (w_last) r_code <= w_code;
    end
  end

`ifdef VGA_DEC_ERR_CNT_EN
  logic [7:0] r_err;
  logic       w_lock_loss;
  assign w_lock_loss = (r_state == LOCKED) && (w_state_nxt == SEARCH);
  always_ff @(posedge i_clk) begin
    if (i_rst)                            r_err <= '0;
    else if (w_lock_loss && r_err != 8'hFF) r_err <= r_err + 8'd1;
  end
  assign o_sync_err_cnt = r_err;
`else
  assign o_sync_err_cnt = 8'h00;
`endif

  assign o_col          = r_col;
  assign o_row          = r_row;
  assign o_locked       = (r_state == LOCKED);
  assign o_pix_valid    = o_locked &&
                          (r_col >= 12'(ACT_X0)) && (r_col <= 12'(ACT_X1)) &&
                          (r_row >= 12'(ACT_Y0)) && (r_row <= 12'(ACT_Y1));
  assign o_letter_code  = r_code;
  assign o_letter_valid = r_lv;

endmodule

// File: tb/tb_vga_frame_decoder.sv
// Scoreboard bench for vga_frame_decoder on a scaled-down 64x32 raster driven by a behavioural glyph generator.
module tb_vga_frame_decoder;
  localparam int TW = 64, TH = 32, HSC = 56, VSL = 30;
  localparam int WX = 8, WY = 8, AX0 = 4, AX1 = 47, AY0 = 2, AY1 = 27;
  localparam int NF = 9;
  localparam int LONG_FRAME = 4, LONG_ROW = 2, RST_FRAME = 7, RST_ROW = 10;
`ifdef VGA_DEC_ERR_CNT_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  logic clk = 1'b0, rst = 1'b1, hs = 1'b1, vs = 1'b1, led = 1'b0;
  logic [11:0] o_col, o_row;
  logic o_pix_valid, o_locked, o_letter_valid;
  logic [7:0] o_letter_code, o_sync_err_cnt;

  always #5 clk = ~clk;

  vga_frame_decoder #(
    .TOTAL_WIDTH(TW), .TOTAL_HEIGHT(TH), .H_SYNC_COLUMN(HSC), .V_SYNC_LINE(VSL),
    .WIN_X(WX), .WIN_Y(WY), .LOCK_LINES(4),
    .ACT_X0(AX0), .ACT_X1(AX1), .ACT_Y0(AY0), .ACT_Y1(AY1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_h_sync(hs), .i_v_sync(vs), .i_led_in(led),
    .o_col(o_col), .o_row(o_row), .o_pix_valid(o_pix_valid), .o_locked(o_locked),
    .o_letter_code(o_letter_code), .o_letter_valid(o_letter_valid), .o_sync_err_cnt(o_sync_err_cnt)
  );

  int n_cmp = 0, n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  int gx = 0, gy = 0, frame = 0;

  // Per-frame stimulus: glyph select, forced-ones window, expected letter.
  logic [7:0] f_sel  [NF] = '{8'h41, 8'h41, 8'h51, 8'h49, 8'h41, 8'h41, 8'h41, 8'h41, 8'h49};
  bit         f_force[NF] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
  bit         f_exp  [NF] = '{0, 1, 1, 1, 0, 1, 1, 0, 1};
  logic [7:0] f_code [NF] = '{8'h00, 8'h41, 8'h51, 8'h49, 8'h00, 8'h41, 8'h3F, 8'h00, 8'h49};

  logic [7:0] rom_a[10] = '{8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE, 8'hFE, 8'hC6, 8'hC6, 8'hC6};
  logic [7:0] rom_q[10] = '{8'hFC, 8'hFE, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'hD6, 8'hFE, 8'h6C, 8'h06};
  logic [7:0] rom_i[10] = '{8'hFE, 8'hFE, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'hFE, 8'hFE};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (frame %0d)", name, act, exp, frame);
    end
  endtask

  function automatic logic [7:0] glyph(input logic [7:0] code, input int r);
    logic [7:0] v;
    v = 8'h00;
    if (r >= 2 && r <= 11) begin
      case (code)
        8'h41:   v = rom_a[r-2];
        8'h51:   v = rom_q[r-2];
        8'h49:   v = rom_i[r-2];
        default: v = 8'h00;
      endcase
    end
    return v;
  endfunction

  task automatic drive();
    logic [7:0] b;
    int fi;
    fi  = (frame < NF) ? frame : NF - 1;
    hs  = !(gx >= HSC);
    vs  = !(gy >= VSL);
    led = 1'b0;
    if (gx >= WX && gx < WX + 8 && gy >= WY && gy < WY + 16) begin
      if (f_force[fi]) led = 1'b1;
      else begin
        b   = glyph(f_sel[fi], gy - WY);
        led = b[7 - (gx - WX)];
      end
    end
  endtask

  // Generator: one pixel per clock; one line of LONG_FRAME is stretched by a clock.
  initial begin
    drive();
    forever begin
      @(posedge clk); #1;
      if (gx >= ((frame == LONG_FRAME && gy == LONG_ROW) ? TW : TW - 1)) begin
        gx = 0;
        if (gy == TH - 1) begin
          gy = 0;
          frame++;
          if (frame < NF && f_exp[frame]) exp_q.push_back(f_code[frame]);
        end else gy++;
      end else gx++;
      drive();
    end
  end

  // Monitor: every letter strobe consumes one expectation.
  always @(negedge clk) begin
    if (o_letter_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL letter_unexpected: got code 0x%0h, expected no strobe (frame %0d)", o_letter_code, frame);
      end else begin
        mon_exp = exp_q.pop_front();
        check("letter_code", o_letter_code, mon_exp);
        check("letter_col", o_col, WX + 8);
        check("letter_row", o_row, WY + 15);
      end
    end
  end

  task automatic check_reset_outs(input string tag);
    check({tag, "_col"}, o_col, 0);
    check({tag, "_row"}, o_row, 0);
    check({tag, "_pix_valid"}, o_pix_valid, 0);
    check({tag, "_locked"}, o_locked, 0);
    check({tag, "_letter_code"}, o_letter_code, 0);
    check({tag, "_letter_valid"}, o_letter_valid, 0);
    check({tag, "_err_cnt"}, o_sync_err_cnt, 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("rst0");
    rst = 1'b0;

    // lock rises the cycle after the V edge is seen
    wait (frame == 0 && gy == VSL && gx == 0);
    @(posedge clk); #1;
    check("lock_pre", o_locked, 0);
    @(posedge clk); #1;
    check("lock_rise", o_locked, 1);
    check("lock_col", o_col, 0);
    check("lock_row", o_row, VSL);

    // coordinate alignment and active-area boundaries
    wait (frame == 1 && gy == WY && gx == WX);
    repeat (2) @(posedge clk); #1;
    check("win_col", o_col, WX);
    check("win_row", o_row, WY);
    check("win_pv", o_pix_valid, 1);
    wait (frame == 1 && gy == WY && gx == AX1);
    repeat (2) @(posedge clk); #1;
    check("pv_x1", o_pix_valid, 1);
    @(posedge clk); #1;
    check("pv_x1p1_col", o_col, AX1 + 1);
    check("pv_x1p1", o_pix_valid, 0);
    wait (frame == 1 && gy == AY1 + 1 && gx == WX);
    repeat (2) @(posedge clk); #1;
    check("pv_y1p1", o_pix_valid, 0);

    // stretched line: lock drops one cycle after the next H edge
    wait (frame == LONG_FRAME && gy == LONG_ROW + 1 && gx == HSC);
    @(posedge clk); #1;
    check("loss_pre", o_locked, 1);
    @(posedge clk); #1;
    check("loss_fall", o_locked, 0);
    check("loss_err_cnt", o_sync_err_cnt, ERR_EXP);
    wait (frame == LONG_FRAME + 1 && gy == 1 && gx == 0);
    #1;
    check("relock", o_locked, 1);
    check("relock_err_cnt", o_sync_err_cnt, ERR_EXP);

    // reset in the middle of the glyph window
    wait (frame == RST_FRAME && gy == RST_ROW && gx == 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outs("rst_mid");
    rst = 1'b0;

    wait (frame == NF);
    repeat (4) @(posedge clk); #1;
    check("pending_letters", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    n_cmp++; n_bad++;
    $display("FAIL timeout: got frame %0d, expected frame %0d", frame, NF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_frame_decoder.md
# vga_frame_decoder

Receive-side counterpart of the VGA timing/glyph generator. Samples the generator's `h_sync`, `v_sync` and pixel (`led_on`) lines, locks to 800x525 timing, and recovers pixel coordinates. It captures the 8x16 glyph window and decodes it back to its 8-bit letter code. It sits on the board-level loopback path and in the glyph-path testbench as the self-check sink.

## Interface
- `TOTAL_WIDTH`, 800: clocks per line
- `TOTAL_HEIGHT`, 525: lines per frame
- `H_SYNC_COLUMN`, 704: column at which `h_sync` goes low
- `V_SYNC_LINE`, 523: line at which `v_sync` goes low
- `WIN_X`, 50 / `WIN_Y`, 50: top-left of the 8x16 glyph window
- `LOCK_LINES`, 4: consecutive good lines required before frame check
- `clk`  in  1  pixel clock, same clock as the generator
- `rst`  in  1  synchronous, active-high reset
- `h_sync`  in  1  horizontal sync, active low
- `v_sync`  in  1  vertical sync, active low
- `led_in`  in  1  pixel bit
- `col`  out  12  recovered column of the current sample
- `row`  out  12  recovered line of the current sample
- `pix_valid`  out  1  `locked` and column 50..689 and line 33..512
- `locked`  out  1  timing lock
- `letter_code`  out  8  decoded glyph code
- `letter_valid`  out  1  one-cycle strobe for `letter_code`
- `sync_err_cnt`  out  8  saturating count of lock losses (see Configuration)

## Operation
- **Input sampling.** All three inputs are registered once: `hs`, `vs`, `px`. The previous values `hs_d` and `vs_d` are kept.
  - Reset values: `hs_d`=0, `vs_d`=0. A low level right after reset is therefore not an edge.
  - H edge: `hs_d`=1 and `hs`=0. V edge: `vs_d`=1 and `vs`=0.
- **Column counter.**
  - On an H edge: load `H_SYNC_COLUMN`.
  - Otherwise: increment, wrapping from `TOTAL_WIDTH-1` to 0.
- **Row counter.**
  - On a V edge: load `V_SYNC_LINE`.
  - Otherwise, on a column wrap: increment, wrapping from `TOTAL_HEIGHT-1` to 0.
  - If a V edge and a column wrap occur in the same cycle, the V edge wins.
- **Period measurement.**
  - `line_len` = cycles between consecutive H edges.
  - `frame_lines` = H edges between consecutive V edges.
- **FSM states.**
  - SEARCH: go to MEASURE on the first H edge; good-line count cleared.
  - MEASURE: each H edge with `line_len`==`TOTAL_WIDTH` increments the good-line count; any other `line_len` returns to SEARCH. When the count is ≥`LOCK_LINES` and a V edge arrives, go to LOCKED.
  - LOCKED: `locked`=1. A bad `line_len`, or a V edge with `frame_lines`≠`TOTAL_HEIGHT`, returns to SEARCH. A bad `frame_lines` on the first V edge after entering LOCKED is ignored.
- **Glyph capture.** Active only while LOCKED.
  - A sample with `row`=`WIN_Y`+r (r 0..15) and `col`=`WIN_X`+c (c 0..7) writes `px` into `cap[r][c]`.
  - c=0 is the leftmost pixel and the MSB of the row byte.
- **Glyph decode.** After the sample at (`WIN_X`+7, `WIN_Y`+15), `cap` is compared against a ROM:
  - 0x41 'A': rows 2..11 = 10,38,6C,C6,C6,FE,FE,C6,C6,C6
  - 0x51 'Q': rows 2..11 = FC,FE,C6,C6,C6,C6,D6,FE,6C,06
  - 0x49 'I': rows 2..11 = FE,FE,30,30,30,30,30,30,FE,FE
  - Rows 0, 1 and 12..15 are 00 for all three glyphs.
  - Exact match drives that code; no match drives 0x3F ('?').
- **Lock loss mid-window.** The partial capture is discarded and no `letter_valid` is produced for that frame.

## Timing
- Pin-to-output latency is 2 cycles: `col`, `row`, `pix_valid` and the sample `px` all describe the same pixel.
- `locked` rises in the cycle after the V edge is detected, and falls in the cycle after the offending edge.
- `letter_valid` is a 1-cycle pulse, 1 cycle after (`WIN_X`+7, `WIN_Y`+15) appears on `col`/`row`. That is at most one pulse per frame.
- `letter_code` holds its value until the next `letter_valid`.
- Reset values: `col`=0, `row`=0, `pix_valid`=0, `locked`=0, `letter_code`=0x00, `letter_valid`=0, `sync_err_cnt`=0. FSM = SEARCH. `cap` cleared.
- Reset asserted mid-frame takes effect on the next edge. Lock requires re-acquisition: at least `LOCK_LINES` lines plus one V edge.

## Configuration
- `VGA_DEC_ERR_CNT_EN` defined: `sync_err_cnt` increments on every LOCKED→SEARCH transition and saturates at 255. It is cleared only by `rst`.
- `VGA_DEC_ERR_CNT_EN` undefined: `sync_err_cnt` is tied to 0 and no counter logic is built.

## Test plan
- **Acquire lock.** Drive the generator with 'A' (0x41) from reset → `locked`=1 after the first V edge following ≥4 good lines. `letter_valid` pulses once per frame with `letter_code`=0x41.
- **Glyph change.** Switch the select to 0x51, then 0x49, one frame apart → the next frames report 0x51, then 0x49.
- **Coordinate alignment.** Pixel at generator (50,50) → `col`=50, `row`=50, `pix_valid`=1 on the same cycle the pixel is sampled. At (700,50) → `pix_valid`=0.
- **Lock loss.** Lengthen one line to 801 clocks → `locked` falls one cycle after that H edge. `sync_err_cnt`=1 with the macro defined, 0 without. Relock occurs on a later frame.
- **Unknown glyph.** Force `led_in`=1 inside the window → `letter_code`=0x3F.
- **Reset mid-frame.** Assert `rst` at row 52 → all outputs reset next cycle, and no `letter_valid` is produced for that frame.
